// File: rtl/drum_pkg.sv
// Shared types and constants for the drum pad hit detector.
package drum_pkg;

  // Per-channel conditioning state.
  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    PRESSED,
    REL_QUAL,
    HOLDOFF
  } hit_state_t;

  // Identifier of the most recent strike.
  typedef logic [1:0] drum_id_t;

  localparam drum_id_t DRUM_NONE = 2'd0;
  localparam drum_id_t DRUM_HAT  = 2'd1;
  localparam drum_id_t DRUM_CYM  = 2'd2;
  localparam drum_id_t DRUM_TOM  = 2'd3;

  localparam logic [7:0] COUNT_MAX = 8'd255;

  // Next value of a saturating strike counter; clear wins over a hit.
  function automatic logic [7:0] next_count(input logic [7:0] count,
                                            input logic       hit,
                                            input logic       clr);
    if (clr) begin
      return 8'd0;
    end else if (hit && (count != COUNT_MAX)) begin
      return count + 8'd1;
    end
    return count;
  endfunction

endpackage

// File: rtl/hit_channel.sv
// One pad channel: 2-flop synchroniser, debounce/holdoff FSM and a
// registered single-cycle hit pulse. The strike output is the
// pre-register version of hit, so the top level can register derived
// status in the same cycle as the pulse.
module hit_channel
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLDOFF_CYCLES  = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pad_raw,
  output logic hit,
  output logic strike,
  output logic busy
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  hit_state_t       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             hit_q, hit_d;
  logic             s;

  assign sync_d = {sync_q[0], pad_raw};
  assign s      = sync_q[1];

  // Next-state, timer and strike decode for the conditioning FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    hit_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (s) state_d = QUAL;
        end
        QUAL: begin
          if (!s) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == DEB_LAST) begin
            state_d = PRESSED;
            timer_d = '0;
            hit_d   = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = REL_QUAL;
            timer_d = '0;
          end
        end
        REL_QUAL: begin
          if (s) begin
            state_d = PRESSED;
            timer_d = '0;
          end else if (timer_q == DEB_LAST) begin
            state_d = HOLDOFF;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        HOLDOFF: begin
          if (timer_q == HOLD_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Synchroniser, FSM state, timer and hit pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      hit_q   <= hit_d;
    end
  end

  assign hit    = hit_q;
  assign strike = hit_d;
  assign busy   = (state_q != IDLE);

endmodule

// File: rtl/drum_hit_detect.sv
// Drum pad front end: three conditioned hit channels plus saturating
// strike counters, a registered any_hit, and a last-hit identifier.
module drum_hit_detect
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLDOFF_CYCLES  = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pad_hat_raw,
  input  logic       pad_cymbal_raw,
  input  logic       pad_tom_raw,
  input  logic       clr_counts,
  output logic       hat_hit,
  output logic       cymbal_hit,
  output logic       tom_hit,
  output logic       any_hit,
  output logic [1:0] last_hit,
  output logic [7:0] hat_count,
  output logic [7:0] cymbal_count,
  output logic [7:0] tom_count,
  output logic [2:0] busy
);

  logic hat_strike, cym_strike, tom_strike;
  logic hat_busy, cym_busy, tom_busy;

  hit_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CNT_W(CNT_W))
    u_hat (.clk(clk), .rst_n(rst_n), .en(en), .pad_raw(pad_hat_raw),
           .hit(hat_hit), .strike(hat_strike), .busy(hat_busy));

  hit_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CNT_W(CNT_W))
    u_cym (.clk(clk), .rst_n(rst_n), .en(en), .pad_raw(pad_cymbal_raw),
           .hit(cymbal_hit), .strike(cym_strike), .busy(cym_busy));

  hit_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CNT_W(CNT_W))
    u_tom (.clk(clk), .rst_n(rst_n), .en(en), .pad_raw(pad_tom_raw),
           .hit(tom_hit), .strike(tom_strike), .busy(tom_busy));

  logic       any_hit_q, any_hit_d;
  drum_id_t   last_hit_q, last_hit_d;
  logic [7:0] hat_count_q, hat_count_d;
  logic [7:0] cym_count_q, cym_count_d;
  logic [7:0] tom_count_q, tom_count_d;

  // Status decode: any_hit and last_hit track the strikes so they line up
  // with the pulses; counters take the visible pulses so a clear in the
  // pulse cycle overrides that increment.
  always_comb begin
    any_hit_d  = hat_strike | cym_strike | tom_strike;
    last_hit_d = last_hit_q;
    if (hat_strike) begin
      last_hit_d = DRUM_HAT;
    end else if (cym_strike) begin
      last_hit_d = DRUM_CYM;
    end else if (tom_strike) begin
      last_hit_d = DRUM_TOM;
    end
    hat_count_d = next_count(hat_count_q, hat_hit, clr_counts);
    cym_count_d = next_count(cym_count_q, cymbal_hit, clr_counts);
    tom_count_d = next_count(tom_count_q, tom_hit, clr_counts);
  end

  // Status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_hit_q   <= 1'b0;
      last_hit_q  <= DRUM_NONE;
      hat_count_q <= '0;
      cym_count_q <= '0;
      tom_count_q <= '0;
    end else begin
      any_hit_q   <= any_hit_d;
      last_hit_q  <= last_hit_d;
      hat_count_q <= hat_count_d;
      cym_count_q <= cym_count_d;
      tom_count_q <= tom_count_d;
    end
  end

  assign any_hit      = any_hit_q;
  assign last_hit     = last_hit_q;
  assign hat_count    = hat_count_q;
  assign cymbal_count = cym_count_q;
  assign tom_count    = tom_count_q;
  assign busy         = {tom_busy, cym_busy, hat_busy};

endmodule

// File: tb/tb_drum_hit_detect.sv
// Directed bench for drum_hit_detect with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
// Loop index k names the rising edge; outputs are sampled 1 ns after it and
// inputs for edge k are set just before it.
module tb_drum_hit_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       pad_hat_raw = 1'b0;
  logic       pad_cymbal_raw = 1'b0;
  logic       pad_tom_raw = 1'b0;
  logic       clr_counts = 1'b0;
  logic       hat_hit, cymbal_hit, tom_hit, any_hit;
  logic [1:0] last_hit;
  logic [7:0] hat_count, cymbal_count, tom_count;
  logic [2:0] busy;

  int checks = 0;
  int failures = 0;

  drum_hit_detect #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pad_hat_raw(pad_hat_raw), .pad_cymbal_raw(pad_cymbal_raw), .pad_tom_raw(pad_tom_raw),
    .clr_counts(clr_counts),
    .hat_hit(hat_hit), .cymbal_hit(cymbal_hit), .tom_hit(tom_hit), .any_hit(any_hit),
    .last_hit(last_hit), .hat_count(hat_count), .cymbal_count(cymbal_count),
    .tom_count(tom_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({hat_hit, cymbal_hit, tom_hit, any_hit} !== 4'b0000) begin
      failures++; $display("FAIL reset_hits got=%b exp=0000", {hat_hit, cymbal_hit, tom_hit, any_hit});
    end
    checks++;
    if ({last_hit, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_status got=%b exp=00000", {last_hit, busy});
    end
    checks++;
    if ({hat_count, cymbal_count, tom_count} !== 24'h0) begin
      failures++; $display("FAIL reset_counts got=%h exp=000000", {hat_count, cymbal_count, tom_count});
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 50; k++) begin
      pad_hat_raw = (k < 30);
      step();
      checks++;
      if (hat_hit !== (k == 6)) begin
        failures++; $display("FAIL clean_hat_hit k=%0d got=%b exp=%b", k, hat_hit, (k == 6));
      end
      checks++;
      if (any_hit !== (k == 6)) begin
        failures++; $display("FAIL clean_any_hit k=%0d got=%b exp=%b", k, any_hit, (k == 6));
      end
      checks++;
      if (busy !== {2'b00, (k >= 2 && k < 44)}) begin
        failures++; $display("FAIL clean_busy k=%0d got=%b exp=%b", k, busy, {2'b00, (k >= 2 && k < 44)});
      end
      checks++;
      if (last_hit !== ((k >= 6) ? 2'd1 : 2'd0)) begin
        failures++; $display("FAIL clean_last_hit k=%0d got=%0d exp=%0d", k, last_hit, (k >= 6) ? 1 : 0);
      end
      checks++;
      if (hat_count !== ((k >= 7) ? 8'd1 : 8'd0)) begin
        failures++; $display("FAIL clean_hat_count k=%0d got=%0d exp=%0d", k, hat_count, (k >= 7) ? 1 : 0);
      end
    end
  endtask

  task automatic test_holdoff();
    for (int k = 0; k < 60; k++) begin
      pad_hat_raw = (k < 10) || (k >= 17 && k <= 20) || (k >= 30 && k < 40);
      step();
      checks++;
      if (hat_hit !== (k == 6 || k == 36)) begin
        failures++; $display("FAIL holdoff_hat_hit k=%0d got=%b exp=%b", k, hat_hit, (k == 6 || k == 36));
      end
    end
    checks++;
    if (hat_count !== 8'd3) begin
      failures++; $display("FAIL holdoff_hat_count got=%0d exp=3", hat_count);
    end
    checks++;
    if (busy !== 3'b000) begin
      failures++; $display("FAIL holdoff_busy_end got=%b exp=000", busy);
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      pad_tom_raw = (k != 2);
      step();
      checks++;
      if (tom_hit !== (k == 9)) begin
        failures++; $display("FAIL bounce_tom_hit k=%0d got=%b exp=%b", k, tom_hit, (k == 9));
      end
    end
    checks++;
    if (tom_count !== 8'd1) begin
      failures++; $display("FAIL bounce_tom_count got=%0d exp=1", tom_count);
    end
    checks++;
    if (last_hit !== 2'd3) begin
      failures++; $display("FAIL bounce_last_hit got=%0d exp=3", last_hit);
    end
    pad_tom_raw = 1'b0;
    repeat (30) step();
    checks++;
    if (busy !== 3'b000) begin
      failures++; $display("FAIL bounce_busy_end got=%b exp=000", busy);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 30; k++) begin
      pad_hat_raw = (k < 10);
      pad_tom_raw = (k < 10);
      step();
      checks++;
      if ({hat_hit, cymbal_hit, tom_hit, any_hit} !== {(k == 6), 1'b0, (k == 6), (k == 6)}) begin
        failures++;
        $display("FAIL simul_hits k=%0d got=%b exp=%b", k, {hat_hit, cymbal_hit, tom_hit, any_hit},
                 {(k == 6), 1'b0, (k == 6), (k == 6)});
      end
      checks++;
      if (last_hit !== ((k >= 6) ? 2'd1 : 2'd3)) begin
        failures++; $display("FAIL simul_last_hit k=%0d got=%0d exp=%0d", k, last_hit, (k >= 6) ? 1 : 3);
      end
    end
    checks++;
    if ({hat_count, cymbal_count, tom_count} !== {8'd4, 8'd0, 8'd2}) begin
      failures++; $display("FAIL simul_counts got=%h exp=040002", {hat_count, cymbal_count, tom_count});
    end
  endtask

  task automatic test_saturation_clear();
    int pulses = 0;
    for (int p = 0; p < 260; p++) begin
      for (int k = 0; k < 24; k++) begin
        pad_cymbal_raw = (k < 8);
        step();
        if (cymbal_hit === 1'b1) pulses++;
      end
      if (p == 254) begin
        checks++;
        if (cymbal_count !== 8'd255) begin
          failures++; $display("FAIL sat_reach_255 got=%0d exp=255", cymbal_count);
        end
      end
    end
    checks++;
    if (pulses !== 260) begin
      failures++; $display("FAIL sat_pulses got=%0d exp=260", pulses);
    end
    checks++;
    if (cymbal_count !== 8'd255) begin
      failures++; $display("FAIL sat_hold_255 got=%0d exp=255", cymbal_count);
    end
    for (int k = 0; k < 24; k++) begin
      pad_cymbal_raw = (k < 8);
      clr_counts = (k == 7);
      step();
      if (k == 6) begin
        checks++;
        if (cymbal_hit !== 1'b1) begin
          failures++; $display("FAIL clr_cym_hit got=%b exp=1", cymbal_hit);
        end
      end
      if (k == 7 || k == 23) begin
        checks++;
        if ({hat_count, cymbal_count, tom_count} !== 24'h0) begin
          failures++; $display("FAIL clr_counts k=%0d got=%h exp=000000", k, {hat_count, cymbal_count, tom_count});
        end
        checks++;
        if (last_hit !== 2'd2) begin
          failures++; $display("FAIL clr_last_hit k=%0d got=%0d exp=2", k, last_hit);
        end
      end
    end
    clr_counts = 1'b0;
  endtask

  task automatic test_abort();
    // Clean tom press so held counters are non-zero.
    for (int k = 0; k < 30; k++) begin
      pad_tom_raw = (k < 8);
      step();
    end
    checks++;
    if (tom_count !== 8'd1) begin
      failures++; $display("FAIL abort_pre_tom_count got=%0d exp=1", tom_count);
    end
    // en dropped while the hat channel is qualifying.
    for (int k = 0; k < 25; k++) begin
      pad_hat_raw = (k < 10);
      en = !(k >= 4 && k < 15);
      step();
      checks++;
      if ({hat_hit, any_hit} !== 2'b00) begin
        failures++; $display("FAIL abort_en_hit k=%0d got=%b exp=00", k, {hat_hit, any_hit});
      end
      checks++;
      if (busy !== {2'b00, (k >= 2 && k < 4)}) begin
        failures++; $display("FAIL abort_en_busy k=%0d got=%b exp=%b", k, busy, {2'b00, (k >= 2 && k < 4)});
      end
    end
    checks++;
    if ({hat_count, tom_count, last_hit} !== {8'd0, 8'd1, 2'd3}) begin
      failures++; $display("FAIL abort_en_held got=%h exp=%h", {hat_count, tom_count, last_hit}, {8'd0, 8'd1, 2'd3});
    end
    // Reset pulsed while the hat channel is qualifying.
    for (int k = 0; k < 4; k++) begin
      pad_hat_raw = 1'b1;
      step();
    end
    checks++;
    if (busy !== 3'b001) begin
      failures++; $display("FAIL abort_rst_qual got=%b exp=001", busy);
    end
    rst_n = 1'b0;
    pad_hat_raw = 1'b0;
    #1;
    checks++;
    if ({busy, last_hit, hat_hit, any_hit} !== 7'b0) begin
      failures++; $display("FAIL abort_rst_status got=%b exp=0000000", {busy, last_hit, hat_hit, any_hit});
    end
    checks++;
    if ({hat_count, cymbal_count, tom_count} !== 24'h0) begin
      failures++; $display("FAIL abort_rst_counts got=%h exp=000000", {hat_count, cymbal_count, tom_count});
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if ({hat_hit, cymbal_hit, tom_hit, any_hit, busy} !== 7'b0) begin
        failures++;
        $display("FAIL abort_rst_after k=%0d got=%b exp=0000000", k, {hat_hit, cymbal_hit, tom_hit, any_hit, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_holdoff();
    test_bounce();
    test_simultaneous();
    test_saturation_clear();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
